// File: rtl/axi_burst_addr_gen.sv
// Burst address generator: accepts burst commands into an active/pending pair
// and expands each burst into a registered per-beat address stream.
//   state | meaning
//   IDLE  | no active burst, beat_valid low
//   RUN   | active burst presenting beats, beat_valid high
module axi_burst_addr_gen #(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 8,
  parameter int DATA_BYTES = 4,
  parameter int ID_W       = 4,
  localparam int SIZE_MAX  = $clog2(DATA_BYTES),
  localparam int LANE_W    = (SIZE_MAX > 0) ? SIZE_MAX : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  input  logic [2:0]        cmd_prot,
  input  logic [ID_W-1:0]   cmd_id,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [ADDR_W-1:0] beat_addr,
  output logic [LANE_W-1:0] beat_lane,
  output logic [ID_W-1:0]   beat_id,
  output logic [2:0]        beat_prot,
  output logic              beat_last,
  output logic              beat_err,
  output logic              busy
);

  localparam logic [2:0] SIZE_MAX_3 = 3'(SIZE_MAX);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [2:0]        prot;
    logic [ID_W-1:0]   id;
    logic              err;
  } cmd_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  cmd_t              cmd_in, act, pend;
  logic              pend_full;
  logic [LEN_W-1:0]  cnt;
  logic              last;
  logic              cmd_fire, beat_fire, last_fire;
  logic              load_cmd, load_pend, to_pend;
  logic              illegal;
  logic [ADDR_W-1:0] cmd_nb, cmd_tot, cmd_aligned, cmd_last_byte;
  logic [ADDR_W-1:0] a_nb, a_tot, a_bound, a_inc, addr_nxt;

  // Legality is decided once, at acceptance, and carried with the command.
  always_comb begin
    cmd_nb        = ADDR_W'(1) << cmd_size;
    cmd_tot       = (ADDR_W'(cmd_len) + ADDR_W'(1)) << cmd_size;
    cmd_aligned   = cmd_addr & ~(cmd_nb - ADDR_W'(1));
    cmd_last_byte = cmd_aligned + cmd_tot - ADDR_W'(1);
    illegal       = 1'b0;
    if (cmd_burst == 2'b11) illegal = 1'b1;
    if (cmd_size > SIZE_MAX_3) illegal = 1'b1;
    if (cmd_burst == 2'b10) begin
      if (!(cmd_len == LEN_W'(1) || cmd_len == LEN_W'(3) ||
            cmd_len == LEN_W'(7) || cmd_len == LEN_W'(15))) illegal = 1'b1;
      if ((cmd_addr & (cmd_nb - ADDR_W'(1))) != '0) illegal = 1'b1;
    end
    if (cmd_burst == 2'b01 && ((cmd_last_byte ^ cmd_addr) >> 12) != '0) illegal = 1'b1;
    cmd_in       = '0;
    cmd_in.addr  = cmd_addr;
    cmd_in.len   = cmd_len;
    cmd_in.size  = cmd_size;
    cmd_in.burst = cmd_burst;
    cmd_in.prot  = cmd_prot;
    cmd_in.id    = cmd_id;
    cmd_in.err   = illegal;
  end

  always_comb begin
    a_nb    = ADDR_W'(1) << act.size;
    a_inc   = act.addr + a_nb;
    a_tot   = (ADDR_W'(act.len) + ADDR_W'(1)) << act.size;
    a_bound = act.addr & ~(a_tot - ADDR_W'(1));
    case (act.burst)
      2'b01:   addr_nxt = (act.addr & ~(a_nb - ADDR_W'(1))) + a_nb;
      2'b10:   addr_nxt = (a_inc == a_bound + a_tot) ? a_bound : a_inc;
      default: addr_nxt = act.addr;
    endcase
  end

  always_comb begin
    cmd_fire  = cmd_valid & ~pend_full;
    beat_fire = (state == RUN) & beat_ready;
    last_fire = beat_fire & last;
    load_cmd  = cmd_fire & ((state == IDLE) | last_fire);
    to_pend   = cmd_fire & ~load_cmd;
    load_pend = last_fire & pend_full;
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire) state_nxt = RUN;
      RUN:     if (last_fire && !load_cmd && !load_pend) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      act       <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      cnt       <= '0;
      last      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_cmd) begin
        act  <= cmd_in;
        cnt  <= '0;
        last <= (cmd_in.len == '0) | cmd_in.err;
      end else if (load_pend) begin
        act  <= pend;
        cnt  <= '0;
        last <= (pend.len == '0) | pend.err;
      end else if (beat_fire) begin
        act.addr <= addr_nxt;
        cnt      <= cnt + LEN_W'(1);
        last     <= (cnt + LEN_W'(1)) == act.len;
      end
      if (to_pend) begin
        pend      <= cmd_in;
        pend_full <= 1'b1;
      end else if (load_pend) begin
        pend_full <= 1'b0;
      end
    end
  end

  assign cmd_ready  = ~pend_full;
  assign beat_valid = (state == RUN);
  assign beat_addr  = act.addr;
  assign beat_id    = act.id;
  assign beat_prot  = act.prot;
  assign beat_last  = last;
  assign beat_err   = act.err;
  assign busy       = (state == RUN) | pend_full;

  if (SIZE_MAX > 0) begin : g_lane
    assign beat_lane = act.addr[LANE_W-1:0];
  end else begin : g_nolane
    assign beat_lane = '0;
  end

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Bench for axi_burst_addr_gen: directed scenarios plus random bursts, every
// beat compared against a queue of expected beats built from burst arithmetic.
module tb_axi_burst_addr_gen;

  logic        clk, reset;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic [2:0]  cmd_prot;
  logic [3:0]  cmd_id;
  logic        beat_valid, beat_ready;
  logic [31:0] beat_addr;
  logic [1:0]  beat_lane;
  logic [3:0]  beat_id;
  logic [2:0]  beat_prot;
  logic        beat_last, beat_err, busy;

  axi_burst_addr_gen dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .cmd_prot(cmd_prot), .cmd_id(cmd_id),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
    .beat_lane(beat_lane), .beat_id(beat_id), .beat_prot(beat_prot),
    .beat_last(beat_last), .beat_err(beat_err), .busy(busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic        last;
    logic        err;
    logic [3:0]  id;
    logic [2:0]  prot;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    rdy_auto = 0;
  bit    rdy_rand = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_illegal(logic [31:0] a, int len, int size, int burst);
    longint nb = longint'(1) << size;
    longint al = (longint'(a) / nb) * nb;
    if (burst == 3) return 1;
    if (size > 2) return 1;
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1;
    if (burst == 2 && (longint'(a) % nb) != 0) return 1;
    if (burst == 1 && ((al + (len + 1) * nb - 1) >> 12) != (longint'(a) >> 12)) return 1;
    return 0;
  endfunction

  task automatic push_model(logic [31:0] a, int len, int size, int burst,
                            logic [2:0] prot, logic [3:0] id);
    beat_t  b;
    longint nb, al, total, bnd, x;
    b.id = id; b.prot = prot;
    if (model_illegal(a, len, size, burst)) begin
      b.addr = a; b.last = 1; b.err = 1;
      exp_q.push_back(b);
      return;
    end
    nb = longint'(1) << size;
    al = (longint'(a) / nb) * nb;
    total = (len + 1) * nb;
    bnd = (longint'(a) / total) * total;
    for (int n = 0; n <= len; n++) begin
      case (burst)
        0:       x = a;
        1:       x = (n == 0) ? longint'(a) : al + n * nb;
        default: x = bnd + ((longint'(a) - bnd) + n * nb) % total;
      endcase
      b.addr = x[31:0]; b.last = (n == len); b.err = 0;
      exp_q.push_back(b);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send_cmd(logic [31:0] a, int len, int size, int burst,
                          logic [2:0] prot, logic [3:0] id);
    int waited = 0;
    cmd_valid = 1; cmd_addr = a; cmd_len = 8'(len); cmd_size = 3'(size);
    cmd_burst = 2'(burst); cmd_prot = prot; cmd_id = id;
    while (!cmd_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("cmd_accept_timeout", 64'(cmd_ready), 1);
    if (cmd_ready) push_model(a, len, size, burst, prot, id);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && !beat_valid && !busy;
    end
    check("drain_to_idle", 64'(ok), 1);
  endtask

  // Beat monitor: drives ready in auto mode, then compares after inputs settle.
  always @(negedge clk) begin
    if (rdy_auto) beat_ready = rdy_rand ? ($urandom % 4 != 0) : 1'b1;
    #1;
    if (reset && beat_valid) begin
      check("beat_expected", 64'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        check("beat_addr", beat_addr, exp_q[0].addr);
        check("beat_lane", beat_lane, exp_q[0].addr[1:0]);
        check("beat_last", beat_last, exp_q[0].last);
        check("beat_err",  beat_err,  exp_q[0].err);
        check("beat_id",   beat_id,   exp_q[0].id);
        check("beat_prot", beat_prot, exp_q[0].prot);
        check("busy_run",  busy, 1);
        if (beat_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int burst, size, len;
    logic [31:0] a;
    cmd_valid = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_burst = 0;
    cmd_prot = 0; cmd_id = 0; beat_ready = 1; reset = 1;
    #3 reset = 0;
    #1;
    check("rst_beat_valid", beat_valid, 0);
    check("rst_beat_addr",  beat_addr, 0);
    check("rst_beat_lane",  beat_lane, 0);
    check("rst_beat_id",    beat_id, 0);
    check("rst_beat_prot",  beat_prot, 0);
    check("rst_beat_last",  beat_last, 0);
    check("rst_beat_err",   beat_err, 0);
    check("rst_busy",       busy, 0);
    check("rst_cmd_ready",  cmd_ready, 1);
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);

    // INCR unaligned start, first beat the cycle after the handshake
    send_cmd(32'h1002, 3, 2, 1, 3'd1, 4'h3);
    check("incr_latency_valid", beat_valid, 1);
    check("incr_first_addr", beat_addr, 32'h1002);
    check("incr_first_lane", beat_lane, 2);
    wait_idle();

    // WRAP, then an illegal WRAP length
    send_cmd(32'h38, 3, 2, 2, 3'd2, 4'h4);
    wait_idle();
    send_cmd(32'h38, 2, 2, 2, 3'd2, 4'h5);
    check("wrap_len2_err", beat_err, 1);
    check("wrap_len2_last", beat_last, 1);
    wait_idle();

    // FIXED with a 3-cycle stall on beat 1
    send_cmd(32'h200, 2, 2, 0, 3'd5, 4'hA);
    @(negedge clk);
    beat_ready = 0;
    for (int i = 0; i < 3; i++) begin
      check("stall_addr", beat_addr, 32'h200);
      check("stall_last", beat_last, 0);
      check("stall_id", beat_id, 4'hA);
      check("stall_prot", beat_prot, 3'd5);
      @(negedge clk);
      if (i == 2) beat_ready = 1;
    end
    @(negedge clk);
    check("fixed_final_last", beat_last, 1);
    wait_idle();

    // Back-to-back bursts, no bubble, cmd_ready low while pending full
    send_cmd(32'h0, 1, 2, 1, 3'd0, 4'h1);
    check("b2b_beat0", beat_addr, 32'h0);
    send_cmd(32'h100, 1, 2, 1, 3'd0, 4'h2);
    check("b2b_beat1", beat_addr, 32'h4);
    check("b2b_cmd_ready_low", cmd_ready, 0);
    @(negedge clk);
    check("b2b_beat2_valid", beat_valid, 1);
    check("b2b_beat2", beat_addr, 32'h100);
    @(negedge clk);
    check("b2b_beat3", beat_addr, 32'h104);
    wait_idle();

    // Page crossing and oversize beat
    send_cmd(32'hFF8, 3, 2, 1, 3'd0, 4'h6);
    check("page_cross_err", beat_err, 1);
    wait_idle();
    send_cmd(32'h400, 1, 3, 1, 3'd0, 4'h7);
    check("size3_err", beat_err, 1);
    wait_idle();

    // Maximum length
    send_cmd(32'h10000, 255, 0, 1, 3'd3, 4'h8);
    wait_idle();

    // Reset during beat 2 of an 8-beat burst with pending full
    send_cmd(32'h2000, 7, 2, 1, 3'd1, 4'h9);
    send_cmd(32'h3000, 1, 2, 1, 3'd1, 4'hB);
    check("rst_test_pend_full", cmd_ready, 0);
    @(negedge clk);
    check("rst_test_beat2", beat_addr, 32'h2008);
    reset = 0;
    exp_q.delete();
    #1;
    check("midrst_beat_valid", beat_valid, 0);
    check("midrst_beat_addr", beat_addr, 0);
    check("midrst_beat_id", beat_id, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    reset = 1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_beat", beat_valid, 0);
    end
    send_cmd(32'h4000, 1, 2, 1, 3'd4, 4'hC);
    wait_idle();

    // Random bursts with random backpressure and command gaps
    rdy_auto = 1; rdy_rand = 1;
    for (int k = 0; k < 300; k++) begin
      int r = $urandom % 16;
      burst = (r < 3) ? 0 : (r < 10) ? 1 : (r < 15) ? 2 : 3;
      size  = ($urandom % 8 == 0) ? 3 : $urandom % 3;
      if (burst == 2 && $urandom % 5 != 0)
        len = (2 << ($urandom % 4)) - 1;
      else
        len = ($urandom % 20 == 0) ? $urandom % 256 : $urandom % 16;
      a = $urandom;
      if ($urandom % 4 == 0) a[11:0] = 12'hFF0 | 12'($urandom % 16);
      if (burst == 2 && size <= 2 && $urandom % 5 != 0) a = a & ~((32'd1 << size) - 1);
      send_cmd(a, len, size, burst, 3'($urandom), 4'($urandom));
      if ($urandom % 4 == 0) repeat ($urandom % 5) @(negedge clk);
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
